// File: rtl/io_switch_led_ctrl_if.sv
// CPU-side IO bus for the LED/switch responder.
//   master: CPU steering logic (drives strobes, decoded selects, address, store data)
//   slave : io_switch_led_ctrl (returns registered read data and its valid pulse)
interface io_switch_led_ctrl_if;
  logic        io_read;      // single-cycle read strobe
  logic        io_write;     // single-cycle write strobe
  logic        led_ctrl;     // LED window decode
  logic        switch_ctrl;  // switch window decode
  logic [2:0]  addr_low;     // address bits [2:0]; bit 2 selects register
  logic [15:0] wdata;        // store data
  logic [15:0] io_rdata;     // read data, 1 cycle after io_read
  logic        rdata_valid;  // io_rdata valid this cycle

  modport master (
    output io_read, io_write, led_ctrl, switch_ctrl, addr_low, wdata,
    input  io_rdata, rdata_valid
  );

  modport slave (
    input  io_read, io_write, led_ctrl, switch_ctrl, addr_low, wdata,
    output io_rdata, rdata_valid
  );
endinterface

// File: rtl/io_switch_led_ctrl.sv
// Memory-mapped IO responder for the board LEDs and switches.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   bus        : CPU IO bus (slave side), registers:
//                  led_ctrl    off0 LED_DATA   R/W
//                  led_ctrl    off1 BLINK_MASK R/W
//                  switch_ctrl off0 SW_STABLE  RO
//                  switch_ctrl off1 SW_EDGE    R / W1C
//                offset is addr_low[2]; read data returns one cycle after io_read
//   switch_pin : raw asynchronous board switches
//   led        : LED drive, LED_DATA with masked bits blanked during blink phase
module io_switch_led_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned BLINK_DIV       = 5000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  io_switch_led_ctrl_if.slave   bus,
  input  logic [15:0]           switch_pin,
  output logic [15:0]           led
);

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_DIV - 1);

  logic [15:0]      led_data_q, led_data_d;
  logic [15:0]      blink_mask_q, blink_mask_d;
  logic [15:0]      sw_meta_q, sw_sync_q, sw_prev_q;
  logic [15:0]      sw_stable_q, sw_stable_d;
  logic [15:0]      sw_rise_q, sw_rise_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             valid_q;

  logic        sel_led, sel_sw, off;
  logic [15:0] w1c_mask, rise_bits;
  logic        unused_addr;

  // Both windows selected at once is a decode conflict: treat as unmapped.
  assign sel_led     = bus.led_ctrl & ~bus.switch_ctrl;
  assign sel_sw      = bus.switch_ctrl & ~bus.led_ctrl;
  assign off         = bus.addr_low[2];
  assign unused_addr = ^bus.addr_low[1:0];

  always_comb begin
    led_data_d   = led_data_q;
    blink_mask_d = blink_mask_q;
    if (bus.io_write && sel_led) begin
      if (off) blink_mask_d = bus.wdata;
      else     led_data_d   = bus.wdata;
    end
  end

  // Debounce: one counter for the whole vector. A change of sw_sync mid-count
  // restarts the hold period so only a vector held steady is accepted.
  always_comb begin
    sw_stable_d = sw_stable_q;
    deb_cnt_d   = deb_cnt_q;
    if (sw_sync_q == sw_stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebLast) begin
      sw_stable_d = sw_sync_q;
      deb_cnt_d   = '0;
    end else if ((deb_cnt_q != '0) && (sw_sync_q != sw_prev_q)) begin
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  // Rising-edge flags: a W1C in the same cycle as a new rise leaves the bit set.
  always_comb begin
    rise_bits = sw_stable_d & ~sw_stable_q;
    w1c_mask  = (bus.io_write && sel_sw && off) ? bus.wdata : 16'h0000;
    sw_rise_d = (sw_rise_q & ~w1c_mask) | rise_bits;
  end

  always_comb begin
    phase_d = phase_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
    end
  end

  // Read mux uses current register values, so a same-cycle write is not seen.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.io_read) begin
      rdata_d = 16'h0000;
      if (sel_led)     rdata_d = off ? blink_mask_q : led_data_q;
      else if (sel_sw) rdata_d = off ? sw_rise_q : sw_stable_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_data_q   <= '0;
      blink_mask_q <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_prev_q    <= '0;
      sw_stable_q  <= '0;
      sw_rise_q    <= '0;
      deb_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      rdata_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      led_data_q   <= led_data_d;
      blink_mask_q <= blink_mask_d;
      sw_meta_q    <= switch_pin;
      sw_sync_q    <= sw_meta_q;
      sw_prev_q    <= sw_sync_q;
      sw_stable_q  <= sw_stable_d;
      sw_rise_q    <= sw_rise_d;
      deb_cnt_q    <= deb_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      rdata_q      <= rdata_d;
      valid_q      <= bus.io_read;
    end
  end

  assign bus.io_rdata    = rdata_q;
  assign bus.rdata_valid = valid_q;
  assign led             = led_data_q & ~(blink_mask_q & {16{phase_q}});

endmodule

// File: tb/tb_io_switch_led_ctrl.sv
module tb_io_switch_led_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] switch_pin;
  logic [15:0] led;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  io_switch_led_ctrl_if bus_if ();

  io_switch_led_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV      (3),
    .CNT_W          (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .switch_pin(switch_pin),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each valid pulse pops one expected read value.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus_if.rdata_valid === 1'b1) begin
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: valid with no read pending, data=%h", bus_if.io_rdata);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.io_rdata !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", bus_if.io_rdata, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus_if.io_read     = 1'b0;
    bus_if.io_write    = 1'b0;
    bus_if.led_ctrl    = 1'b0;
    bus_if.switch_ctrl = 1'b0;
    bus_if.addr_low    = 3'b000;
    bus_if.wdata       = 16'h0000;
  endtask

  task automatic do_read(input logic lc, input logic sc, input logic [2:0] a,
                         input logic [15:0] exp);
    @(negedge clk);
    bus_if.io_read     = 1'b1;
    bus_if.led_ctrl    = lc;
    bus_if.switch_ctrl = sc;
    bus_if.addr_low    = a;
    exp_q.push_back(exp);
    @(negedge clk);
    idle();
  endtask

  task automatic do_write(input logic lc, input logic sc, input logic [2:0] a,
                          input logic [15:0] d);
    @(negedge clk);
    bus_if.io_write    = 1'b1;
    bus_if.led_ctrl    = lc;
    bus_if.switch_ctrl = sc;
    bus_if.addr_low    = a;
    bus_if.wdata       = d;
    @(negedge clk);
    idle();
  endtask

  task automatic test_por();
    total++;
    if (led !== 16'h0000) begin
      bad++;
      $display("FAIL por_led: got %h expected 0000", led);
    end
    do_read(1'b1, 1'b0, 3'b000, 16'h0000);
    do_read(1'b0, 1'b1, 3'b100, 16'h0000);
  endtask

  task automatic test_led();
    do_write(1'b1, 1'b0, 3'b000, 16'hA5C3);
    total++;
    if (led !== 16'hA5C3) begin
      bad++;
      $display("FAIL led_write: got %h expected a5c3", led);
    end
    do_read(1'b1, 1'b0, 3'b011, 16'hA5C3);  // low addr bits ignored
    @(negedge clk);
    total++;
    if (bus_if.rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse: got %b expected 0", bus_if.rdata_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_write(1'b1, 1'b0, 3'b100, 16'h0000);
    @(negedge clk);
    bus_if.io_read  = 1'b1;
    bus_if.led_ctrl = 1'b1;
    bus_if.addr_low = 3'b000;
    exp_q.push_back(16'hA5C3);
    @(negedge clk);
    bus_if.addr_low = 3'b100;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    idle();
  endtask

  task automatic test_debounce();
    switch_pin = 16'h0081;
    repeat (5) @(negedge clk);
    // Strobe held over edges 6 and 7: old value, then accepted value.
    bus_if.io_read     = 1'b1;
    bus_if.switch_ctrl = 1'b1;
    bus_if.addr_low    = 3'b000;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0081);
    @(negedge clk);
    @(negedge clk);
    idle();
    do_read(1'b0, 1'b1, 3'b100, 16'h0081);
    // Three-cycle glitch is shorter than the hold period.
    switch_pin = 16'h0001;
    repeat (3) @(negedge clk);
    switch_pin = 16'h0081;
    repeat (10) @(negedge clk);
    do_read(1'b0, 1'b1, 3'b000, 16'h0081);
    do_read(1'b0, 1'b1, 3'b100, 16'h0081);
    // Writes to SW_STABLE are ignored.
    do_write(1'b0, 1'b1, 3'b000, 16'hFFFF);
    do_read(1'b0, 1'b1, 3'b000, 16'h0081);
  endtask

  task automatic test_edge_race();
    switch_pin = 16'h0080;  // falling only
    repeat (10) @(negedge clk);
    do_read(1'b0, 1'b1, 3'b000, 16'h0080);
    do_read(1'b0, 1'b1, 3'b100, 16'h0081);
    switch_pin = 16'h0081;
    repeat (5) @(negedge clk);
    bus_if.io_write    = 1'b1;
    bus_if.switch_ctrl = 1'b1;
    bus_if.addr_low    = 3'b100;
    bus_if.wdata       = 16'h0081;
    @(negedge clk);
    idle();
    do_read(1'b0, 1'b1, 3'b100, 16'h0001);
    do_read(1'b0, 1'b1, 3'b000, 16'h0081);
  endtask

  task automatic test_reset();
    switch_pin = 16'h0000;
    do_write(1'b1, 1'b0, 3'b000, 16'hFFFF);
    do_read(1'b1, 1'b0, 3'b000, 16'hFFFF);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (led !== 16'h0000 || bus_if.io_rdata !== 16'h0000 || bus_if.rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: led=%h rdata=%h valid=%b expected 0000/0000/0",
               led, bus_if.io_rdata, bus_if.rdata_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    do_read(1'b1, 1'b0, 3'b000, 16'h0000);
    do_read(1'b1, 1'b0, 3'b100, 16'h0000);
    do_read(1'b0, 1'b1, 3'b000, 16'h0000);
    do_read(1'b0, 1'b1, 3'b100, 16'h0000);
  endtask

  task automatic test_blink();
    logic [15:0] exp;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_if.io_write = 1'b1;
    bus_if.led_ctrl = 1'b1;
    bus_if.addr_low = 3'b000;
    bus_if.wdata    = 16'h00FF;
    @(negedge clk);
    bus_if.addr_low = 3'b100;
    bus_if.wdata    = 16'h000F;
    @(negedge clk);
    idle();
    // k = clock edges since reset release; phase flips every 3 edges.
    for (int k = 2; k < 20; k++) begin
      exp = (((k / 3) % 2) == 1) ? 16'h00F0 : 16'h00FF;
      total++;
      if (led !== exp) begin
        bad++;
        $display("FAIL blink k=%0d: got %h expected %h", k, led, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_unmapped();
    do_write(1'b1, 1'b0, 3'b100, 16'h0000);
    do_write(1'b1, 1'b0, 3'b000, 16'h1234);
    do_read(1'b0, 1'b0, 3'b000, 16'h0000);
    do_read(1'b1, 1'b1, 3'b000, 16'h0000);
    do_write(1'b1, 1'b1, 3'b000, 16'hDEAD);  // conflicting selects: ignored
    do_write(1'b0, 1'b0, 3'b000, 16'hBEEF);  // unmapped: ignored
    @(negedge clk);
    bus_if.io_read  = 1'b1;
    bus_if.io_write = 1'b1;
    bus_if.led_ctrl = 1'b1;
    bus_if.addr_low = 3'b000;
    bus_if.wdata    = 16'h5678;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    idle();
    total++;
    if (led !== 16'h5678) begin
      bad++;
      $display("FAIL rw_same_cycle_led: got %h expected 5678", led);
    end
    do_read(1'b1, 1'b0, 3'b000, 16'h5678);
  endtask

  initial begin
    rst        = 1'b0;
    switch_pin = 16'h0000;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_por();
    test_led();
    test_back_to_back();
    test_debounce();
    test_edge_race();
    test_reset();
    test_blink();
    test_unmapped();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rd_missing: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_switch_led_ctrl.md
Name: io_switch_led_ctrl

Overview:
Memory-mapped IO responder that sits behind the CPU's memory-or-IO steering logic. It services the CPU's IO read and IO write strobes for the LED and switch address windows. It owns the 16 board LEDs (data register plus per-bit blink mask) and the 16 board switches (2-flop synchronizer, debouncer, sticky rising-edge flags). Read data returns to the register-writeback mux with a fixed 1-cycle latency.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive cycles a changed synchronized switch vector must hold before it is accepted (minimum 2)
BLINK_DIV, 5000000, cycles per blink phase toggle (minimum 1)
CNT_W, 24, width of the debounce and blink counters; must hold DEBOUNCE_CYCLES-1 and BLINK_DIV-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
io_read  in  1  CPU IO read strobe, single-cycle
io_write  in  1  CPU IO write strobe, single-cycle
led_ctrl  in  1  address decoded to LED window (0xFFFFFC60..0xFFFFFC67)
switch_ctrl  in  1  address decoded to switch window (0xFFFFFC70..0xFFFFFC77)
addr_low  in  3  ALU address bits [2:0]
wdata  in  16  CPU store data [15:0]
switch_pin  in  16  raw board switches, asynchronous
io_rdata  out  16  read data
rdata_valid  out  1  io_rdata valid this cycle
led  out  16  board LED drive

Behaviour:
- Reset (rst=0, asynchronous) clears: LED_DATA, BLINK_MASK, sync flops, SW_STABLE, SW_EDGE, both counters, blink phase, io_rdata and rdata_valid. led=0 during reset and after release.
- Register map. Offset is addr_low[2]; addr_low[1:0] is ignored:
  - LED_DATA: led_ctrl, offset 0, R/W.
  - BLINK_MASK: led_ctrl, offset 1, R/W.
  - SW_STABLE: switch_ctrl, offset 0, RO.
  - SW_EDGE: switch_ctrl, offset 1, R / write-1-to-clear.
- Writes take effect at the clk edge that samples io_write=1.
  - Writes with neither ctrl asserted are ignored.
  - Writes to SW_STABLE are ignored.
- Reads: io_rdata and rdata_valid are registered on the edge that samples io_read=1, so data appears 1 cycle after the strobe.
  - rdata_valid is high for exactly one cycle per strobe.
  - Reading with neither ctrl asserted returns 0, with rdata_valid still pulsed.
  - Reads have no side effects; reading SW_EDGE does not clear it.
- io_read and io_write in the same cycle: the write is performed and the read returns the pre-write value.
- led_ctrl and switch_ctrl both high: the access is ignored; a read returns 0 and is valid.
- Synchronizer: 2 flops, switch_pin -> sw_sync.
- Debounce: single vector-wide counter.
  - Counter clears whenever sw_sync == SW_STABLE.
  - Otherwise it increments each cycle.
  - At the edge where the counter == DEBOUNCE_CYCLES-1 and sw_sync != SW_STABLE: SW_STABLE <= sw_sync and the counter clears.
  - Any change of sw_sync while counting restarts the count, because the counter compares against the latest sw_sync held for consecutive cycles. An sw_sync change while count > 0 resets the counter to 0.
  - Net latency from a clean pin change to SW_STABLE update is DEBOUNCE_CYCLES+2 edges (+1 for asynchronous sampling).
- SW_EDGE:
  - On a SW_STABLE update, SW_EDGE |= new & ~old (rising bits only).
  - A W1C write to a bit in the same cycle its rising edge is detected leaves the bit set: set wins.
- Blink:
  - Counter counts 0..BLINK_DIV-1 and wraps.
  - Phase toggles at each wrap.
  - led = LED_DATA & ~(BLINK_MASK & {16{phase}}); combinational from registers.
  - LED_DATA and BLINK_MASK writes do not reset the blink counter or phase.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_DIV=3.
1. Reset: hold rst=0 mid-operation with LED_DATA=0xFFFF and SW_EDGE nonzero -> led=0, io_rdata=0, rdata_valid=0 immediately (asynchronous); all registers read 0 after release.
2. LED write/read: io_write, led_ctrl, addr_low=0, wdata=0xA5C3 -> led=0xA5C3 next cycle. Then io_read at the same address -> io_rdata=0xA5C3 with rdata_valid=1 exactly one cycle later, then rdata_valid=0.
3. Debounce:
   - switch_pin 0x0000->0x0081 held -> SW_STABLE=0x0081 on the 6th edge; SW_EDGE=0x0081.
   - A glitch to 0x0001 lasting 3 cycles then returning -> SW_STABLE unchanged and SW_EDGE unchanged.
4. Edge clear race: write SW_EDGE with wdata=0x0081 in the same cycle a new rising edge on bit 0 is accepted -> SW_EDGE=0x0001. A falling-only change 0x0081->0x0080 sets no flags.
5. Blink: LED_DATA=0x00FF, BLINK_MASK=0x000F -> led alternates 0x00FF / 0x00F0 every 3 cycles, starting at 0x00FF after reset.
6. Unmapped and conflicting access:
   - Read with both ctrls low -> io_rdata=0, valid pulsed.
   - Simultaneous io_read+io_write to LED_DATA (old 0x1234, new 0x5678) -> io_rdata=0x1234, and LED_DATA=0x5678 thereafter.
